// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the 1-to-4 demultiplexer and its dispatcher:
//   NUM_CH        number of consumer channels
//   sel_t         channel select type
//   disp_state_e  dispatcher buffer state (EMPTY / FULL)
// ---------------------------------------------------------------------------
package demux_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } disp_state_e;

endpackage : demux_pkg

// File: rtl/demuxer4.sv
// ---------------------------------------------------------------------------
// demuxer4
// Combinational 1-to-4 demultiplexer: routes the single-bit input to the
// output selected by sel; all other outputs are 0.
// Ports:
//   in   - bit to route
//   sel  - output index
//   out  - one-hot (or all-zero when in=0) outputs
// ---------------------------------------------------------------------------
module demuxer4
  import demux_pkg::*;
(
  input  logic              in,
  input  sel_t              sel,
  output logic [NUM_CH-1:0] out
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign out[gi] = in && (sel == sel_t'(gi));
  end

endmodule : demuxer4

// File: rtl/demux4_dispatcher.sv
// ---------------------------------------------------------------------------
// demux4_dispatcher
// Valid/ready front end for demuxer4. Holds one input word and steers it to
// one of four consumer channels, chosen either from an external select or
// by a round-robin pointer that advances every BURST round-robin captures.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   en                   - accept enable (a buffered word still drains)
//   mode                 - 0: fixed select from sel, 1: round-robin
//   sel                  - target channel in fixed mode
//   in_valid/in_data     - input word stream
//   in_ready             - a word can be accepted this cycle
//   out_valid            - one-hot valid on the target channel
//   out_data             - buffered word, shared by all channels
//   out_ready            - per-channel ready
//   cur_sel              - target channel of the buffered word
//   rr_ptr               - round-robin pointer
//   busy                 - buffer holds a word
// ---------------------------------------------------------------------------
module demux4_dispatcher
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  sel_t              sel,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic [NUM_CH-1:0] out_valid,
  output logic [WIDTH-1:0]  out_data,
  input  logic [NUM_CH-1:0] out_ready,
  output sel_t              cur_sel,
  output sel_t              rr_ptr,
  output logic              busy
);

  // BURST is at most 16, so a 4-bit counter always suffices.
  localparam int               CNT_W      = 4;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST - 1);

  disp_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  sel_t             cur_sel_q, cur_sel_d;
  sel_t             rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic target_ready;
  logic capture;
  logic deliver;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    cur_sel_d   = cur_sel_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;

    target_ready = out_ready[cur_sel_q];
    deliver      = (state_q == FULL) && target_ready;
    // A full buffer can take a new word in the same cycle it is delivered.
    in_ready     = en && !rst && ((state_q == EMPTY) || target_ready);
    capture      = in_valid && in_ready;

    if (capture) begin
      state_d = FULL;
      data_d  = in_data;
      if (mode) begin
        cur_sel_d = rr_ptr_q;
        if (burst_cnt_q == BURST_LAST) begin
          rr_ptr_d    = rr_ptr_q + sel_t'(1);
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end else begin
        cur_sel_d = sel;
      end
    end else if (deliver) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      data_q      <= '0;
      cur_sel_q   <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      cur_sel_q   <= cur_sel_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Valid fan-out comes only from registered state, so out_valid has no
  // combinational path from any input.
  demuxer4 u_demuxer4 (
    .in  (state_q == FULL),
    .sel (cur_sel_q),
    .out (out_valid)
  );

  assign out_data = data_q;
  assign cur_sel  = cur_sel_q;
  assign rr_ptr   = rr_ptr_q;
  assign busy     = (state_q == FULL);

endmodule : demux4_dispatcher
